// File: rtl/alimentador_rolhas_pkg.sv
// Shared definitions for the cork feeder: FSM state encodings and default
// parameter values used by the feeder, its stock counter and the display.
package alimentador_rolhas_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPlace  = 2'd1,
    StDone   = 2'd2,
    StStarve = 2'd3
  } state_e;

  localparam int unsigned StockMaxDef    = 99;
  localparam int unsigned InitStockDef   = 20;
  localparam int unsigned RefillDef      = 15;
  localparam int unsigned PlaceCyclesDef = 4;
  localparam int unsigned LowLevelDef    = 5;
  localparam int unsigned StockWDef      = 7;

endpackage

// File: rtl/alimentador_rolhas_contador_estoque.sv
// Saturating cork stock counter.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (loads INIT_STOCK)
//   inc_en      - add REFILL corks this edge
//   dec_en      - remove one cork this edge
//   stock       - registered cork count
//   EMPTY, LOW  - stock == 0, stock <= LOW_LEVEL
module contador_estoque
  import alimentador_rolhas_pkg::*;
#(
  parameter int unsigned STOCK_MAX  = StockMaxDef,
  parameter int unsigned INIT_STOCK = InitStockDef,
  parameter int unsigned REFILL     = RefillDef,
  parameter int unsigned LOW_LEVEL  = LowLevelDef,
  parameter int unsigned W          = StockWDef
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_en,
  input  logic         dec_en,
  output logic [W-1:0] stock,
  output logic         EMPTY,
  output logic         LOW
);

  // One extra bit so the net sum never wraps before saturation.
  localparam int unsigned WE = W + 1;
  localparam logic [W:0] RefillExt = WE'(REFILL);
  localparam logic [W:0] MaxExt    = WE'(STOCK_MAX);

  logic [W-1:0] stock_q, stock_d;
  logic [W:0]   sum_d;

  // Net sum first, then clamp, so refill + dispense at the ceiling stays put.
  always_comb begin
    sum_d = {1'b0, stock_q};
    if (inc_en) sum_d = sum_d + RefillExt;
    if (dec_en && (sum_d != '0)) sum_d = sum_d - 1'b1;
    if (sum_d > MaxExt) stock_d = W'(STOCK_MAX);
    else                stock_d = sum_d[W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stock_q <= W'(INIT_STOCK);
    else       stock_q <= stock_d;
  end

  assign stock = stock_q;
  assign EMPTY = (stock_q == '0);
  assign LOW   = (stock_q <= W'(LOW_LEVEL));

endmodule

// File: rtl/alimentador_rolhas.sv
// Cork feeder for the sealing station. Answers a level-held seal request GP
// by consuming one cork and, PLACE_CYCLES edges after acceptance, raising RO
// until GP drops. Tracks stock with operator refill and raises alarms.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   GP         - seal request (level)
//   ADD        - operator refill button; each rising edge adds REFILL
//   RO         - cork placed (registered)
//   BUSY       - placement in progress or done
//   EMPTY, LOW - stock alarms
//   STARVED    - request waiting on empty stock
//   stock      - current cork count
//   state      - FSM state for debug/display
module alimentador_rolhas
  import alimentador_rolhas_pkg::*;
#(
  parameter int unsigned STOCK_MAX    = StockMaxDef,
  parameter int unsigned INIT_STOCK   = InitStockDef,
  parameter int unsigned REFILL       = RefillDef,
  parameter int unsigned PLACE_CYCLES = PlaceCyclesDef,
  parameter int unsigned LOW_LEVEL    = LowLevelDef,
  parameter int unsigned W            = StockWDef
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         GP,
  input  logic         ADD,
  output logic         RO,
  output logic         BUSY,
  output logic         EMPTY,
  output logic         LOW,
  output logic         STARVED,
  output logic [W-1:0] stock,
  output logic [1:0]   state
);

  localparam int unsigned TimerW = (PLACE_CYCLES > 1) ? $clog2(PLACE_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(PLACE_CYCLES - 1);

  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic              add_q;
  logic              ro_q, busy_q, starved_q;

  logic has_stock, accept, refill;

  assign has_stock = (stock != '0);
  // A dropped GP in STARVE returns to IDLE without consuming a cork.
  assign accept    = GP && has_stock && ((state_q == StIdle) || (state_q == StStarve));
  assign refill    = ADD && !add_q;

  contador_estoque #(
    .STOCK_MAX (STOCK_MAX),
    .INIT_STOCK(INIT_STOCK),
    .REFILL    (REFILL),
    .LOW_LEVEL (LOW_LEVEL),
    .W         (W)
  ) u_contador_estoque (
    .clk   (clk),
    .reset (reset),
    .inc_en(refill),
    .dec_en(accept),
    .stock (stock),
    .EMPTY (EMPTY),
    .LOW   (LOW)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      add_q     <= 1'b0;
      ro_q      <= 1'b0;
      busy_q    <= 1'b0;
      starved_q <= 1'b0;
    end else begin
      add_q <= ADD;
      case (state_q)
        StIdle: begin
          if (GP) begin
            if (has_stock) begin
              state_q <= StPlace;
              timer_q <= TimerLoad;
              busy_q  <= 1'b1;
            end else begin
              state_q   <= StStarve;
              starved_q <= 1'b1;
            end
          end
        end
        StPlace: begin
          // GP is ignored here: the cork is already consumed.
          if (timer_q == '0) begin
            state_q <= StDone;
            ro_q    <= 1'b1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        StDone: begin
          if (!GP) begin
            state_q <= StIdle;
            ro_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        StStarve: begin
          if (!GP) begin
            state_q   <= StIdle;
            starved_q <= 1'b0;
          end else if (has_stock) begin
            state_q   <= StPlace;
            timer_q   <= TimerLoad;
            starved_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign RO      = ro_q;
  assign BUSY    = busy_q;
  assign STARVED = starved_q;
  assign state   = state_q;

endmodule

// File: tb/tb_alimentador_rolhas.sv
module tb_alimentador_rolhas;

  localparam int PC = 4;

  logic       clk, reset, GP, ADD;
  logic       RO, BUSY, EMPTY, LOW, STARVED;
  logic [6:0] stock;
  logic [1:0] state;

  int n_pass  = 0;
  int n_total = 0;

  alimentador_rolhas dut (
    .clk    (clk),
    .reset  (reset),
    .GP     (GP),
    .ADD    (ADD),
    .RO     (RO),
    .BUSY   (BUSY),
    .EMPTY  (EMPTY),
    .LOW    (LOW),
    .STARVED(STARVED),
    .stock  (stock),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full request from IDLE with stock > 0: accept, place, drop GP, back to IDLE.
  task automatic consume_one();
    GP = 1'b1;
    tick();
    repeat (PC) tick();
    GP = 1'b0;
    tick();
  endtask

  task automatic refill_pulse();
    ADD = 1'b1;
    tick();
    ADD = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_total++;
    if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state);
    else n_pass++;
    n_total++;
    if (stock !== 7'd20) $display("FAIL reset_stock: got %0d expected 20", stock);
    else n_pass++;
    n_total++;
    if ({RO, BUSY, STARVED, EMPTY, LOW} !== 5'b00000)
      $display("FAIL reset_flags: got %b expected 00000", {RO, BUSY, STARVED, EMPTY, LOW});
    else n_pass++;
  endtask

  task automatic test_basic();
    GP = 1'b1;
    tick();  // E0
    n_total++;
    if (stock !== 7'd19) $display("FAIL basic_stock: got %0d expected 19", stock);
    else n_pass++;
    n_total++;
    if ({BUSY, RO, state} !== {1'b1, 1'b0, 2'd1})
      $display("FAIL basic_accept: got %b expected 1001", {BUSY, RO, state});
    else n_pass++;
    repeat (PC - 1) tick();  // E3
    n_total++;
    if (RO !== 1'b0) $display("FAIL basic_ro_early: got %b expected 0", RO);
    else n_pass++;
    tick();  // E4
    n_total++;
    if ({RO, state} !== {1'b1, 2'd2})
      $display("FAIL basic_ro_rise: got %b expected 110", {RO, state});
    else n_pass++;
    repeat (3) tick();  // GP held: no re-trigger
    n_total++;
    if ({RO, state, stock} !== {1'b1, 2'd2, 7'd19})
      $display("FAIL basic_hold: got ro=%b st=%0d stock=%0d expected 1 2 19", RO, state, stock);
    else n_pass++;
    GP = 1'b0;
    tick();
    n_total++;
    if ({RO, BUSY, state} !== {1'b0, 1'b0, 2'd0})
      $display("FAIL basic_release: got %b expected 0000", {RO, BUSY, state});
    else n_pass++;
  endtask

  task automatic test_starve();
    repeat (18) consume_one();
    n_total++;
    if ({stock, EMPTY, LOW} !== {7'd1, 1'b0, 1'b1})
      $display("FAIL starve_stock1: got stock=%0d E=%b L=%b expected 1 0 1", stock, EMPTY, LOW);
    else n_pass++;
    consume_one();
    n_total++;
    if ({stock, EMPTY} !== {7'd0, 1'b1})
      $display("FAIL starve_empty: got stock=%0d E=%b expected 0 1", stock, EMPTY);
    else n_pass++;
    GP = 1'b1;
    tick();
    n_total++;
    if ({state, STARVED, BUSY} !== {2'd3, 1'b1, 1'b0})
      $display("FAIL starve_enter: got %b expected 1110", {state, STARVED, BUSY});
    else n_pass++;
    GP = 1'b0;
    tick();
    n_total++;
    if ({state, STARVED, stock} !== {2'd0, 1'b0, 7'd0})
      $display("FAIL starve_abandon: got st=%0d S=%b stock=%0d expected 0 0 0",
               state, STARVED, stock);
    else n_pass++;
    GP = 1'b1;
    tick();
    ADD = 1'b1;
    tick();  // Er
    n_total++;
    if ({state, stock} !== {2'd3, 7'd15})
      $display("FAIL starve_refill: got st=%0d stock=%0d expected 3 15", state, stock);
    else n_pass++;
    ADD = 1'b0;
    tick();  // Er+1
    n_total++;
    if ({state, stock, STARVED} !== {2'd1, 7'd14, 1'b0})
      $display("FAIL starve_accept: got st=%0d stock=%0d S=%b expected 1 14 0",
               state, stock, STARVED);
    else n_pass++;
    repeat (PC - 1) tick();  // Er+4
    n_total++;
    if (RO !== 1'b0) $display("FAIL starve_ro_early: got %b expected 0", RO);
    else n_pass++;
    tick();  // Er+5
    n_total++;
    if (RO !== 1'b1) $display("FAIL starve_ro_rise: got %b expected 1", RO);
    else n_pass++;
    GP = 1'b0;
    tick();
  endtask

  task automatic test_refill_accept();
    repeat (4) consume_one();
    n_total++;
    if (stock !== 7'd10) $display("FAIL refill_pre: got %0d expected 10", stock);
    else n_pass++;
    ADD = 1'b1;
    GP  = 1'b1;
    tick();
    n_total++;
    if ({state, stock} !== {2'd1, 7'd24})
      $display("FAIL refill_same_edge: got st=%0d stock=%0d expected 1 24", state, stock);
    else n_pass++;
    repeat (PC) tick();
    GP = 1'b0;
    tick();
    repeat (4) tick();  // ADD high for 10 edges total
    ADD = 1'b0;
    tick();
    n_total++;
    if ({state, stock} !== {2'd0, 7'd24})
      $display("FAIL refill_held: got st=%0d stock=%0d expected 0 24", state, stock);
    else n_pass++;
  endtask

  task automatic test_saturation();
    repeat (5) refill_pulse();
    n_total++;
    if (stock !== 7'd99) $display("FAIL sat_fill: got %0d expected 99", stock);
    else n_pass++;
    repeat (9) consume_one();
    n_total++;
    if (stock !== 7'd90) $display("FAIL sat_90: got %0d expected 90", stock);
    else n_pass++;
    refill_pulse();
    n_total++;
    if (stock !== 7'd99) $display("FAIL sat_clamp: got %0d expected 99", stock);
    else n_pass++;
    refill_pulse();
    n_total++;
    if (stock !== 7'd99) $display("FAIL sat_at_max: got %0d expected 99", stock);
    else n_pass++;
    ADD = 1'b1;
    GP  = 1'b1;
    tick();
    n_total++;
    if ({state, stock} !== {2'd1, 7'd99})
      $display("FAIL sat_net_sum: got st=%0d stock=%0d expected 1 99", state, stock);
    else n_pass++;
    ADD = 1'b0;
    repeat (PC) tick();
    GP = 1'b0;
    tick();
  endtask

  task automatic test_low();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (14) consume_one();
    n_total++;
    if ({stock, LOW, EMPTY} !== {7'd6, 1'b0, 1'b0})
      $display("FAIL low_at_6: got stock=%0d L=%b E=%b expected 6 0 0", stock, LOW, EMPTY);
    else n_pass++;
    consume_one();
    n_total++;
    if ({stock, LOW} !== {7'd5, 1'b1})
      $display("FAIL low_at_5: got stock=%0d L=%b expected 5 1", stock, LOW);
    else n_pass++;
  endtask

  task automatic test_pulse();
    GP = 1'b1;
    tick();
    GP = 1'b0;
    n_total++;
    if ({state, stock} !== {2'd1, 7'd4})
      $display("FAIL pulse_accept: got st=%0d stock=%0d expected 1 4", state, stock);
    else n_pass++;
    repeat (PC - 1) tick();
    n_total++;
    if ({state, BUSY, RO} !== {2'd1, 1'b1, 1'b0})
      $display("FAIL pulse_no_abort: got %b expected 0110", {state, BUSY, RO});
    else n_pass++;
    tick();
    n_total++;
    if (RO !== 1'b1) $display("FAIL pulse_ro_high: got %b expected 1", RO);
    else n_pass++;
    tick();
    n_total++;
    if ({RO, state, stock} !== {1'b0, 2'd0, 7'd4})
      $display("FAIL pulse_ro_low: got ro=%b st=%0d stock=%0d expected 0 0 4", RO, state, stock);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    GP = 1'b1;
    tick();
    tick();  // PLACE, timer 2
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({state, RO, BUSY, stock} !== {2'd0, 1'b0, 1'b0, 7'd20})
      $display("FAIL mid_reset: got st=%0d ro=%b busy=%b stock=%0d expected 0 0 0 20",
               state, RO, BUSY, stock);
    else n_pass++;
    GP = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    GP    = 1'b1;
    tick();
    n_total++;
    if ({stock, BUSY, state} !== {7'd19, 1'b1, 2'd1})
      $display("FAIL mid_reaccept: got stock=%0d busy=%b st=%0d expected 19 1 1",
               stock, BUSY, state);
    else n_pass++;
    repeat (PC) tick();
    n_total++;
    if (RO !== 1'b1) $display("FAIL mid_ro: got %b expected 1", RO);
    else n_pass++;
    GP = 1'b0;
    tick();
    n_total++;
    if ({RO, state} !== {1'b0, 2'd0})
      $display("FAIL mid_idle: got ro=%b st=%0d expected 0 0", RO, state);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    GP    = 1'b0;
    ADD   = 1'b0;
    #12;
    reset = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_starve();
    test_refill_accept();
    test_saturation();
    test_low();
    test_pulse();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
